// File: rtl/arcadia_cart_pkg.sv
// Shared types and helpers for the Arcadia cartridge controller.
package arcadia_cart_pkg;

  // Load sequencer states; the encoding is also visible on the debug port.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    SIZE  = 3'd3,
    RUN   = 3'd4
  } cart_state_t;

  // Value returned to the CPU whenever the RAM is not being read on its behalf.
  localparam logic [7:0] CART_FILL = 8'hFF;

  // Smallest 2^k-1 that covers max_addr, never narrower than min_w bits.
  // Smearing the top set bit downwards gives the covering all-ones value.
  function automatic int unsigned size_mask(input int unsigned max_addr,
                                            input int unsigned min_w);
    int unsigned m;
    m = max_addr;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    m = m | ((32'd1 << min_w) - 32'd1);
    return m;
  endfunction

endpackage

// File: rtl/arcadia_cart_ctrl.sv
// Cartridge RAM owner: sequences clear/download/sizing of a cart image and
// then serves the 2650 cartridge fetch port from the same single-port BRAM.
//
// Handshakes:
//   ioctl: a byte is taken on any cycle where ioctl_wr=1 and ioctl_wait=0
//          (and the index matches); ioctl_wait is a level, not a pulse.
//   cpu:   cpu_rd is a one-cycle request sampled at edge N; cpu_ack is a
//          one-cycle pulse two cycles later with cpu_rdata valid alongside.
module arcadia_cart_ctrl
  import arcadia_cart_pkg::*;
#(
  parameter int         ADDR_W     = 14,
  parameter logic [7:0] CART_INDEX = 8'd1,
  parameter int         MIN_MASK_W = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  input  logic              cpu_rd,
  input  logic [14:0]       cpu_addr,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_hold,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout,
  output logic              cart_valid,
  output logic [ADDR_W-1:0] cart_mask,
  output cart_state_t       dbg_state
);

  cart_state_t       state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              buf_full_q, buf_full_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [7:0]        buf_data_q, buf_data_d;
  logic [ADDR_W-1:0] max_addr_q, max_addr_d;
  logic              any_q, any_d;
  logic              dl_prev_q, dl_prev_d;
  logic              cart_valid_q, cart_valid_d;
  logic [ADDR_W-1:0] cart_mask_q, cart_mask_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_din_q, ram_din_d;
  logic              rd1_q, rd1_d;
  logic              rd1_ram_q, rd1_ram_d;
  logic              ack_q, ack_d;
  logic              ack_ram_q, ack_ram_d;

  logic dl_qual;
  logic dl_rise;
  logic restart;
  logic wr_accept;
  logic addr_in_range;
  logic cpu_ram_rd;
  logic unused_cpu_hi;

  // Upper CPU address bits alias into the cart window; the mask does the rest.
  assign unused_cpu_hi = ^cpu_addr[14:ADDR_W];

  // Request qualification shared by the FSM and the CPU read pipeline.
  always_comb begin
    dl_qual       = ioctl_download && (ioctl_index == CART_INDEX);
    dl_rise       = dl_qual && !dl_prev_q;
    restart       = (state_q == RUN) && dl_rise;
    ioctl_wait    = (state_q == CLEAR) || ((state_q == LOAD) && buf_full_q);
    wr_accept     = (state_q == LOAD) && ioctl_wr && !ioctl_wait &&
                    (ioctl_index == CART_INDEX);
    addr_in_range = (ioctl_addr[24:ADDR_W] == '0);
    cpu_ram_rd    = (state_q == RUN) && !restart && cpu_rd;
  end

  // Next-state logic: load sequencer, write buffer and CPU read pipeline.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    buf_full_d   = buf_full_q;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
    max_addr_d   = max_addr_q;
    any_d        = any_q;
    dl_prev_d    = dl_qual;
    cart_valid_d = cart_valid_q;
    cart_mask_d  = cart_mask_q;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    rd1_d        = cpu_rd;
    rd1_ram_d    = cpu_ram_rd;
    ack_d        = rd1_q;
    // A read whose data would land after a restart is answered with fill.
    ack_ram_d    = rd1_ram_q && (state_q == RUN) && !restart;

    case (state_q)
      IDLE: begin
        if (dl_qual) begin
          state_d      = CLEAR;
          clr_cnt_d    = '0;
          cart_valid_d = 1'b0;
          max_addr_d   = '0;
          any_d        = 1'b0;
        end
      end
      CLEAR: begin
        ram_we_d   = 1'b1;
        ram_addr_d = clr_cnt_q;
        ram_din_d  = 8'h00;
        clr_cnt_d  = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (buf_full_q) begin
          ram_we_d   = 1'b1;
          ram_addr_d = buf_addr_q;
          ram_din_d  = buf_data_q;
          buf_full_d = 1'b0;
        end else if (wr_accept) begin
          any_d = 1'b1;
          if (addr_in_range) begin
            buf_full_d = 1'b1;
            buf_addr_d = ioctl_addr[ADDR_W-1:0];
            buf_data_d = ioctl_dout;
            if (ioctl_addr[ADDR_W-1:0] > max_addr_q) begin
              max_addr_d = ioctl_addr[ADDR_W-1:0];
            end
          end else begin
            max_addr_d = '1;
          end
        end
        // Leave only once nothing is buffered or being buffered this cycle.
        if (!dl_qual && !buf_full_q && !wr_accept) begin
          state_d = SIZE;
        end
      end
      SIZE: begin
        if (!any_q) begin
          cart_valid_d = 1'b0;
          state_d      = IDLE;
        end else begin
          cart_mask_d  = ADDR_W'(size_mask(32'(max_addr_q), MIN_MASK_W));
          cart_valid_d = 1'b1;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (restart) begin
          state_d      = CLEAR;
          clr_cnt_d    = '0;
          cart_valid_d = 1'b0;
          max_addr_d   = '0;
          any_d        = 1'b0;
        end else if (cpu_ram_rd) begin
          ram_addr_d = cpu_addr[ADDR_W-1:0] & cart_mask_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      clr_cnt_q    <= '0;
      buf_full_q   <= 1'b0;
      buf_addr_q   <= '0;
      buf_data_q   <= 8'h00;
      max_addr_q   <= '0;
      any_q        <= 1'b0;
      dl_prev_q    <= 1'b0;
      cart_valid_q <= 1'b0;
      cart_mask_q  <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= 8'h00;
      rd1_q        <= 1'b0;
      rd1_ram_q    <= 1'b0;
      ack_q        <= 1'b0;
      ack_ram_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      buf_full_q   <= buf_full_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
      max_addr_q   <= max_addr_d;
      any_q        <= any_d;
      dl_prev_q    <= dl_prev_d;
      cart_valid_q <= cart_valid_d;
      cart_mask_q  <= cart_mask_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      rd1_q        <= rd1_d;
      rd1_ram_q    <= rd1_ram_d;
      ack_q        <= ack_d;
      ack_ram_q    <= ack_ram_d;
    end
  end

  // Outputs; read data is taken straight from the BRAM q in the ack cycle.
  always_comb begin
    ram_we     = ram_we_q;
    ram_addr   = ram_addr_q;
    ram_din    = ram_din_q;
    cart_valid = cart_valid_q;
    cart_mask  = cart_mask_q;
    cpu_hold   = (state_q != RUN);
    cpu_ack    = ack_q;
    cpu_rdata  = 8'h00;
    if (ack_q) begin
      cpu_rdata = ack_ram_q ? ram_dout : CART_FILL;
    end
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_arcadia_cart_ctrl.sv
// Bench for arcadia_cart_ctrl: vector table for reset/idle behaviour,
// scripted cart downloads, and randomized CPU reads against a memory model.
module tb_arcadia_cart_ctrl;
  import arcadia_cart_pkg::*;

  localparam int ADDR_W  = 14;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int MIN_W   = 11;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset_n;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic              cpu_rd;
  logic [14:0]       cpu_addr;
  logic [7:0]        cpu_rdata;
  logic              cpu_ack;
  logic              cpu_hold;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic              cart_valid;
  logic [ADDR_W-1:0] cart_mask;
  cart_state_t       dbg_state;

  always #5 clk = ~clk;

  arcadia_cart_ctrl #(.ADDR_W(ADDR_W), .CART_INDEX(8'd1), .MIN_MASK_W(MIN_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .cpu_hold(cpu_hold),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .cart_valid(cart_valid), .cart_mask(cart_mask), .dbg_state(dbg_state)
  );

  // Single-port BRAM: q is the word addressed on the previous cycle.
  logic [7:0] bram [DEPTH];
  always @(posedge clk) begin
    if (ram_we) bram[ram_addr] <= ram_din;
    ram_dout <= bram[ram_addr];
  end

  // RAM write counter, cleared at the start of each download.
  int   wr_total;
  logic wr_clr;
  always @(posedge clk) begin
    if (wr_clr) wr_total <= 0;
    else if (ram_we) wr_total <= wr_total + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [7:0]  model_mem [DEPTH];
  int          model_max;
  bit          model_any;
  int          model_mask;
  int          n_in_range;
  logic [24:0] dl_a[$];
  logic [7:0]  dl_d[$];

  function automatic int exp_mask(input int max_a);
    int k = MIN_W;
    while (((1 << k) - 1) < max_a) k++;
    return (1 << k) - 1;
  endfunction

  // ---------------- scoreboard / driver tasks ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random CPU read burst; each read must ack exactly two edges later.
  task automatic cpu_burst(input int n, input bit in_run);
    logic [8:0] exp_q[$];
    logic [8:0] e;
    logic [14:0] a;
    bit r;
    for (int i = 0; i < n + 2; i++) begin
      r = (i < n) ? ($urandom_range(0, 3) != 0) : 1'b0;
      a = 15'($urandom_range(0, 32767));
      cpu_rd   = r;
      cpu_addr = a;
      if (in_run) exp_q.push_back({r, model_mem[a[13:0] & model_mask[13:0]]});
      else        exp_q.push_back({r, CART_FILL});
      tick();
      if (i >= 1) begin
        e = exp_q.pop_front();
        chk("burst_ack", 32'(cpu_ack), 32'(e[8]));
        if (e[8]) chk("burst_rdata", 32'(cpu_rdata), 32'(e[7:0]));
      end
    end
    cpu_rd = 1'b0;
  endtask

  task automatic cpu_read1(input logic [14:0] a, input logic [7:0] exp, input string name);
    cpu_rd = 1'b1; cpu_addr = a;
    tick();
    cpu_rd = 1'b0;
    chk({name, "_ack_early"}, 32'(cpu_ack), 32'd0);
    tick();
    chk({name, "_ack"}, 32'(cpu_ack), 32'd1);
    chk({name, "_data"}, 32'(cpu_rdata), 32'(exp));
  endtask

  task automatic model_reset_image();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    model_max = 0; model_any = 1'b0; n_in_range = 0;
  endtask

  task automatic start_download();
    model_reset_image();
    ioctl_download = 1'b1; ioctl_index = 8'd1; wr_clr = 1'b1;
    tick();
    wr_clr = 1'b0;
    chk("dl_enter_clear", 32'(dbg_state), 32'(CLEAR));
    chk("dl_clear_wait", 32'(ioctl_wait), 32'd1);
    chk("dl_clear_hold", 32'(cpu_hold), 32'd1);
    chk("dl_clear_valid", 32'(cart_valid), 32'd0);
  endtask

  // Count CLEAR cycles; 'seen' of them have already been observed.
  task automatic wait_clear(input int seen);
    int cnt = seen;
    int bad = 0;
    for (int g = 0; g < DEPTH + 16; g++) begin
      tick();
      if (dbg_state != CLEAR) break;
      cnt++;
      if (ioctl_wait !== 1'b1) bad++;
    end
    chk("clear_cycles", 32'(cnt), 32'(DEPTH));
    chk("clear_wait_high", 32'(bad), 32'd0);
    chk("clear_to_load", 32'(dbg_state), 32'(LOAD));
  endtask

  // Send dl_a/dl_d writing on every cycle ioctl_wait permits, then finish.
  task automatic send_and_finish();
    int idx = 0;
    int alt_bad = 0;
    int bad = 0;
    int n = dl_a.size();
    bit prev_wr = 1'b0;
    for (int g = 0; g < 4 * n + 8 && idx < n; g++) begin
      if (ioctl_wait !== prev_wr) alt_bad++;
      if (!ioctl_wait) begin
        ioctl_wr = 1'b1; ioctl_addr = dl_a[idx]; ioctl_dout = dl_d[idx];
        model_any = 1'b1;
        if (dl_a[idx] < 25'(DEPTH)) begin
          model_mem[dl_a[idx][13:0]] = dl_d[idx];
          if (int'(dl_a[idx]) > model_max) model_max = int'(dl_a[idx]);
          n_in_range++;
        end else begin
          model_max = DEPTH - 1;
        end
        idx++; prev_wr = 1'b1;
      end else begin
        ioctl_wr = 1'b0; prev_wr = 1'b0;
      end
      tick();
    end
    ioctl_wr = 1'b0;
    chk("load_all_sent", 32'(idx), 32'(n));
    chk("load_wait_alternates", 32'(alt_bad), 32'd0);
    chk("load_last_pending_wait", 32'(ioctl_wait), 32'(n > 0));
    ioctl_download = 1'b0;
    for (int g = 0; g < 8 && dbg_state != SIZE; g++) tick();
    chk("load_to_size", 32'(dbg_state), 32'(SIZE));
    chk("writes_before_size", 32'(wr_total), 32'(DEPTH + n_in_range));
    for (int i = 0; i < DEPTH; i++) if (bram[i] !== model_mem[i]) bad++;
    chk("ram_image", 32'(bad), 32'd0);
    tick();
    if (model_any) begin
      model_mask = exp_mask(model_max);
      chk("size_state", 32'(dbg_state), 32'(RUN));
      chk("size_mask", 32'(cart_mask), 32'(model_mask));
      chk("size_valid", 32'(cart_valid), 32'd1);
      chk("size_hold", 32'(cpu_hold), 32'd0);
    end else begin
      chk("size_state_empty", 32'(dbg_state), 32'(IDLE));
      chk("size_valid_empty", 32'(cart_valid), 32'd0);
      chk("size_hold_empty", 32'(cpu_hold), 32'd1);
    end
  endtask

  task automatic sparse_image(input int top);
    dl_a.delete(); dl_d.delete();
    for (int i = 0; i < 128; i++) begin
      dl_a.push_back(25'(i)); dl_d.push_back(8'($urandom_range(0, 255)));
    end
    dl_a.push_back(25'(top)); dl_d.push_back(8'($urandom_range(1, 255)));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst_n;
    logic        dl;
    logic [7:0]  idx;
    cart_state_t st;
    logic        wait_o;
    logic        hold;
    logic        valid;
    logic [13:0] mask;
  } vec_t;
  vec_t vecs[5];

  initial begin
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = 8'h00; cpu_rd = 1'b0; cpu_addr = '0; wr_clr = 1'b1;
    model_mask = 0;

    vecs[0] = '{1'b0, 1'b0, 8'd0,   IDLE, 1'b0, 1'b1, 1'b0, 14'd0};
    vecs[1] = '{1'b0, 1'b1, 8'd1,   IDLE, 1'b0, 1'b1, 1'b0, 14'd0};
    vecs[2] = '{1'b1, 1'b1, 8'd2,   IDLE, 1'b0, 1'b1, 1'b0, 14'd0};
    vecs[3] = '{1'b1, 1'b1, 8'h81,  IDLE, 1'b0, 1'b1, 1'b0, 14'd0};
    vecs[4] = '{1'b1, 1'b0, 8'd1,   IDLE, 1'b0, 1'b1, 1'b0, 14'd0};
    for (int i = 0; i < 5; i++) begin
      reset_n = vecs[i].rst_n; ioctl_download = vecs[i].dl; ioctl_index = vecs[i].idx;
      tick();
      chk("vec_state", 32'(dbg_state), 32'(vecs[i].st));
      chk("vec_wait", 32'(ioctl_wait), 32'(vecs[i].wait_o));
      chk("vec_hold", 32'(cpu_hold), 32'(vecs[i].hold));
      chk("vec_valid", 32'(cart_valid), 32'(vecs[i].valid));
      chk("vec_mask", 32'(cart_mask), 32'(vecs[i].mask));
      chk("vec_ram_we", 32'(ram_we), 32'd0);
      chk("vec_ack", 32'(cpu_ack), 32'd0);
      chk("vec_rdata", 32'(cpu_rdata), 32'd0);
    end
    wr_clr = 1'b0;

    // Reads while idle return fill without touching RAM.
    cpu_burst(20, 1'b0);

    // 4096-byte image, data = low address byte.
    dl_a.delete(); dl_d.delete();
    for (int i = 0; i < 4096; i++) begin
      dl_a.push_back(25'(i)); dl_d.push_back(8'(i));
    end
    start_download();
    wait_clear(1);
    send_and_finish();
    cpu_rd = 1'b1; cpu_addr = 15'h1005;
    tick();
    cpu_rd = 1'b0;
    chk("rd1005_ram_addr", 32'(ram_addr), 32'h005);
    chk("rd1005_no_ack", 32'(cpu_ack), 32'd0);
    tick();
    chk("rd1005_ack", 32'(cpu_ack), 32'd1);
    chk("rd1005_data", 32'(cpu_rdata), 32'h05);
    cpu_burst(40, 1'b1);

    // Foreign index while running changes nothing.
    ioctl_download = 1'b1; ioctl_index = 8'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idx2_state", 32'(dbg_state), 32'(RUN));
      chk("idx2_wait", 32'(ioctl_wait), 32'd0);
      chk("idx2_valid", 32'(cart_valid), 32'd1);
    end
    ioctl_download = 1'b0;
    tick();

    // 1500-byte image: clamps to the 2 KB minimum.
    sparse_image(1499);
    start_download();
    wait_clear(1);
    send_and_finish();
    chk("mask_1500", 32'(cart_mask), 32'h07FF);
    cpu_burst(40, 1'b1);

    // 6000-byte image.
    sparse_image(5999);
    start_download();
    wait_clear(1);
    send_and_finish();
    chk("mask_6000", 32'(cart_mask), 32'h1FFF);
    cpu_read1(15'h1770, 8'h00, "rd1770");
    cpu_read1(15'd200, 8'h00, "rd_cleared");
    cpu_burst(40, 1'b1);

    // Re-download with a CPU read on the same cycle, then a zero-byte load.
    model_reset_image();
    ioctl_download = 1'b1; ioctl_index = 8'd1; wr_clr = 1'b1;
    cpu_rd = 1'b1; cpu_addr = 15'h0005;
    tick();
    cpu_rd = 1'b0; wr_clr = 1'b0;
    chk("abort_hold", 32'(cpu_hold), 32'd1);
    chk("abort_state", 32'(dbg_state), 32'(CLEAR));
    chk("abort_valid", 32'(cart_valid), 32'd0);
    chk("abort_ack_early", 32'(cpu_ack), 32'd0);
    tick();
    chk("abort_ack", 32'(cpu_ack), 32'd1);
    chk("abort_fill", 32'(cpu_rdata), 32'hFF);
    chk("abort_wait", 32'(ioctl_wait), 32'd1);
    wait_clear(2);
    dl_a.delete(); dl_d.delete();
    send_and_finish();

    // Reset in the middle of a load.
    start_download();
    wait_clear(1);
    ioctl_wr = 1'b1; ioctl_addr = 25'd5; ioctl_dout = 8'h5A;
    tick();
    ioctl_wr = 1'b0;
    chk("midload_buffered", 32'(ioctl_wait), 32'd1);
    reset_n = 1'b0; ioctl_download = 1'b0;
    tick();
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_valid", 32'(cart_valid), 32'd0);
    chk("rst_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_mask", 32'(cart_mask), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_state", 32'(dbg_state), 32'(IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
